// File: rtl/ad9361_tx_deframer.sv
// +---------------------------------------------------------------------------+
// | Module      : ad9361_tx_deframer                                          |
// | Description : Frame-locking receiver for the 1R1T AD9361 TX word stream;  |
// |               rebuilds 12-bit I/Q samples and counts framing errors.      |
// |               Optional ramp checker: AD9361_TX_DEFRAMER_RAMP_CHECK_EN.    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module ad9361_tx_deframer #(
  parameter int LOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic                     in_frame,
  input  logic [5:0]               in_data,
  output logic                     out_valid,
  output logic [11:0]              out_i,
  output logic [11:0]              out_q,
  output logic                     locked,
  output logic [ERR_CNT_WIDTH-1:0] frame_err_cnt,
  output logic [ERR_CNT_WIDTH-1:0] ramp_err_cnt
);

  localparam logic [1:0] c_HUNT      = 2'd0;
  localparam logic [1:0] c_SYNC      = 2'd1;
  localparam logic [1:0] c_LOCKED    = 2'd2;
  localparam logic [7:0] c_LOCK_LAST = 8'(LOCK_COUNT - 1);

  logic                     r_frame;
  logic                     r_frame_d;
  logic                     r_skip;
  logic [5:0]               r_data;
  logic [1:0]               r_state;
  logic [1:0]               w_state_nxt;
  logic [1:0]               r_phase;
  logic [7:0]               r_good_cnt;
  logic [5:0]               r_i_hi;
  logic [5:0]               r_q_hi;
  logic [5:0]               r_i_lo;
  logic                     r_out_valid;
  logic [11:0]              r_out_i;
  logic [11:0]              r_out_q;
  logic [ERR_CNT_WIDTH-1:0] r_frame_err_cnt;

  logic        w_exp_frame;
  logic        w_mismatch;
  logic        w_err;
  logic        w_edge;
  logic        w_last;
  logic        w_emit;
  logic [11:0] w_new_i;
  logic [11:0] w_new_q;

  // Input stage; r_skip hides a mismatching word from the edge detector.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_frame   <= 1'b0;
      r_data    <= 6'd0;
      r_frame_d <= 1'b0;
      r_skip    <= 1'b0;
    end else begin
      r_frame   <= in_frame;
      r_data    <= in_data;
      r_frame_d <= r_frame;
      r_skip    <= w_err;
    end
  end

  assign w_exp_frame = ~r_phase[1];
  assign w_mismatch  = (r_state != c_HUNT) && (r_frame != w_exp_frame);
  assign w_err       = enable && w_mismatch;
  assign w_edge      = !r_skip && !r_frame_d && r_frame;
  assign w_last      = (r_phase == 2'd3);
  assign w_emit      = enable && (r_state == c_LOCKED) && !w_mismatch && w_last;
  assign w_new_i     = {r_i_hi, r_i_lo};
  assign w_new_q     = {r_q_hi, r_data};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = c_HUNT;
    end else begin
      case (r_state)
        c_HUNT: begin
          if (w_edge) begin
            w_state_nxt = c_SYNC;
          end
        end
        c_SYNC: begin
          if (w_mismatch) begin
            w_state_nxt = c_HUNT;
          end else if (w_last && (r_good_cnt == c_LOCK_LAST)) begin
            w_state_nxt = c_LOCKED;
          end
        end
        c_LOCKED: begin
          if (w_mismatch) begin
            w_state_nxt = c_HUNT;
          end
        end
        default: w_state_nxt = c_HUNT;
      endcase
    end
  end

  always_comb begin
    locked = 1'b0;
    if (r_state == c_LOCKED) begin
      locked = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase    <= 2'd0;
      r_good_cnt <= 8'd0;
    end else begin
      if (!enable || w_mismatch) begin
        r_phase <= 2'd0;
      end else if (r_state == c_HUNT) begin
        r_phase <= w_edge ? 2'd1 : 2'd0;
      end else begin
        r_phase <= r_phase + 2'd1;
      end

      if (w_state_nxt != c_SYNC) begin
        r_good_cnt <= 8'd0;
      end else if ((r_state == c_SYNC) && w_last) begin
        r_good_cnt <= r_good_cnt + 8'd1;
      end
    end
  end

  // Partial-sample holding registers; the Q low word is taken straight from r_data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_i_hi <= 6'd0;
      r_q_hi <= 6'd0;
      r_i_lo <= 6'd0;
    end else if (enable && !w_mismatch) begin
      if (r_state == c_HUNT) begin
        if (w_edge) begin
          r_i_hi <= r_data;
        end
      end else begin
        case (r_phase)
          2'd0:    r_i_hi <= r_data;
          2'd1:    r_q_hi <= r_data;
          2'd2:    r_i_lo <= r_data;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid     <= 1'b0;
      r_out_i         <= 12'd0;
      r_out_q         <= 12'd0;
      r_frame_err_cnt <= '0;
    end else begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_i <= w_new_i;
        r_out_q <= w_new_q;
      end
      if (w_err && !(&r_frame_err_cnt)) begin
        r_frame_err_cnt <= r_frame_err_cnt + 1'b1;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign out_i         = r_out_i;
  assign out_q         = r_out_q;
  assign frame_err_cnt = r_frame_err_cnt;

`ifdef AD9361_TX_DEFRAMER_RAMP_CHECK_EN
  logic                     r_ref_valid;
  logic [ERR_CNT_WIDTH-1:0] r_ramp_err_cnt;

  // The first sample of each lock only seeds the reference.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ref_valid    <= 1'b0;
      r_ramp_err_cnt <= '0;
    end else begin
      if (w_state_nxt != c_LOCKED) begin
        r_ref_valid <= 1'b0;
      end else if (w_emit) begin
        r_ref_valid <= 1'b1;
      end
      if (w_emit && r_ref_valid && (w_new_i != (r_out_i + 12'd1)) && !(&r_ramp_err_cnt)) begin
        r_ramp_err_cnt <= r_ramp_err_cnt + 1'b1;
      end
    end
  end

  assign ramp_err_cnt = r_ramp_err_cnt;
`else
  assign ramp_err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ad9361_tx_deframer.sv
// +---------------------------------------------------------------------------+
// | Module      : tb_ad9361_tx_deframer                                       |
// | Description : Directed self-checking bench for ad9361_tx_deframer.        |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_ad9361_tx_deframer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable = 1'b0;
  logic        in_frame = 1'b0;
  logic [5:0]  in_data = 6'd0;

  logic        out_valid;
  logic [11:0] out_i;
  logic [11:0] out_q;
  logic        locked;
  logic [15:0] frame_err_cnt;
  logic [15:0] ramp_err_cnt;

  logic        s_out_valid;
  logic [11:0] s_out_i;
  logic [11:0] s_out_q;
  logic        s_locked;
  logic [3:0]  s_frame_err_cnt;
  logic [3:0]  s_ramp_err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  ad9361_tx_deframer dut (
    .clk(clk), .rstn(rstn), .enable(enable), .in_frame(in_frame), .in_data(in_data),
    .out_valid(out_valid), .out_i(out_i), .out_q(out_q), .locked(locked),
    .frame_err_cnt(frame_err_cnt), .ramp_err_cnt(ramp_err_cnt)
  );

  ad9361_tx_deframer #(.LOCK_COUNT(4), .ERR_CNT_WIDTH(4)) dut_sat (
    .clk(clk), .rstn(rstn), .enable(enable), .in_frame(in_frame), .in_data(in_data),
    .out_valid(s_out_valid), .out_i(s_out_i), .out_q(s_out_q), .locked(s_locked),
    .frame_err_cnt(s_frame_err_cnt), .ramp_err_cnt(s_ramp_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] wd(input logic [11:0] i, input logic [11:0] q, input int p);
    case (p)
      0:       return i[11:6];
      1:       return q[11:6];
      2:       return i[5:0];
      default: return q[5:0];
    endcase
  endfunction

  task automatic drive_word(input logic f, input logic [5:0] d, input logic en);
    @(negedge clk);
    in_frame = f;
    in_data  = d;
    enable   = en;
  endtask

  task automatic drive_sample(input logic [11:0] i, input logic [11:0] q, input logic [3:0] fr);
    for (int p = 0; p < 4; p++) begin
      drive_word(fr[p], wd(i, q, p), 1'b1);
    end
  endtask

  // At phase 1 of a sample, the outputs show the result of the previous sample.
  task automatic send(input logic [11:0] i, input logic [11:0] q, input logic [3:0] fr,
                      input logic ev, input logic [11:0] ei, input logic [11:0] eq,
                      input logic el0, input logic el1);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      chk($sformatf("out_valid_p%0d", p), {31'd0, out_valid}, (p == 1) ? {31'd0, ev} : 32'd0);
      if (p == 1 && ev) begin
        chk("out_i", {20'd0, out_i}, {20'd0, ei});
        chk("out_q", {20'd0, out_q}, {20'd0, eq});
      end
      if (p == 0) chk("locked_p0", {31'd0, locked}, {31'd0, el0});
      if (p == 1) chk("locked_p1", {31'd0, locked}, {31'd0, el1});
      in_frame = fr[p];
      in_data  = wd(i, q, p);
      enable   = 1'b1;
    end
  endtask

  function automatic logic [11:0] ramp_val(input int k);
    return (k < 10) ? 12'(k) : 12'(k + 1);
  endfunction

  initial begin
    // Power-on reset
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_i", {20'd0, out_i}, 32'd0);
    chk("rst_q", {20'd0, out_q}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_ferr", {16'd0, frame_err_cnt}, 32'd0);
    chk("rst_rerr", {16'd0, ramp_err_cnt}, 32'd0);
    rstn = 1'b1;
    drive_word(1'b0, 6'd0, 1'b1);
    drive_word(1'b0, 6'd0, 1'b1);

    // Lock and decode I=0xABC, Q=0x123
    for (int n = 1; n <= 8; n++) begin
      send(12'hABC, 12'h123, 4'b0011, n >= 6, 12'hABC, 12'h123, n >= 6, n >= 5);
    end

    // Inverted frame on the phase-2 word while locked, then relock
    send(12'hABC, 12'h123, 4'b0111, 1'b1, 12'hABC, 12'h123, 1'b1, 1'b1);
    for (int n = 1; n <= 6; n++) begin
      send(12'hABC, 12'h123, 4'b0011, n >= 6, 12'hABC, 12'h123, n >= 6, n >= 5);
    end
    chk("ferr_after_mismatch", {16'd0, frame_err_cnt}, 32'd1);

    // Enable low for three cycles, then relock
    drive_word(1'b0, 6'd0, 1'b0);
    drive_word(1'b0, 6'd0, 1'b0);
    drive_word(1'b0, 6'd0, 1'b0);
    for (int n = 1; n <= 6; n++) begin
      send(12'hABC, 12'h123, 4'b0011, n >= 6, 12'hABC, 12'h123, n >= 6, n >= 5);
    end
    chk("ferr_after_enable", {16'd0, frame_err_cnt}, 32'd1);

    // Asynchronous reset mid-stream while locked
    @(negedge clk);
    in_frame = 1'b0;
    in_data  = 6'd0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_i", {20'd0, out_i}, 32'd0);
    chk("arst_q", {20'd0, out_q}, 32'd0);
    chk("arst_locked", {31'd0, locked}, 32'd0);
    chk("arst_ferr", {16'd0, frame_err_cnt}, 32'd0);
    chk("arst_rerr", {16'd0, ramp_err_cnt}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drive_word(1'b0, 6'd0, 1'b1);
    drive_word(1'b0, 6'd0, 1'b1);

    // I ramp with the value 10 skipped
    for (int k = 0; k <= 15; k++) begin
      send(ramp_val(k), 12'hFFF - ramp_val(k), 4'b0011, k >= 5,
           ramp_val((k > 0) ? k - 1 : 0), 12'hFFF - ramp_val((k > 0) ? k - 1 : 0),
           k >= 5, k >= 4);
    end
    @(negedge clk);
`ifdef AD9361_TX_DEFRAMER_RAMP_CHECK_EN
    chk("ramp_err", {16'd0, ramp_err_cnt}, 32'd1);
`else
    chk("ramp_err", {16'd0, ramp_err_cnt}, 32'd0);
`endif
    chk("ferr_after_ramp", {16'd0, frame_err_cnt}, 32'd0);

    // Twenty framing errors, then two more to confirm saturation holds
    for (int e = 0; e < 20; e++) begin
      drive_sample(12'hABC, 12'h123, 4'b0001);
    end
    @(negedge clk);
    chk("ferr_20", {16'd0, frame_err_cnt}, 32'd20);
    chk("ferr_sat_20", {28'd0, s_frame_err_cnt}, 32'd15);
    chk("locked_after_errs", {31'd0, locked}, 32'd0);
    for (int e = 0; e < 2; e++) begin
      drive_sample(12'hABC, 12'h123, 4'b0001);
    end
    @(negedge clk);
    chk("ferr_22", {16'd0, frame_err_cnt}, 32'd22);
    chk("ferr_sat_hold", {28'd0, s_frame_err_cnt}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ad9361_tx_deframer.md
Name: ad9361_tx_deframer

Overview:
- Sample-rate receiver for the 1R1T AD9361 transmit data stream (tx_frame / 6-bit tx_data) that the FPGA drives toward the radio.
- Locks to frame alignment, reassembles 12-bit I/Q words and reports framing health.
- Used as the loopback/monitor end of the TX port in simulation and as an on-chip TX path checker in hardware builds.
- clk runs at the word (DDR edge) rate: one 6-bit word per cycle.

Parameters:
- LOCK_COUNT, 4: consecutive correctly framed samples required before lock (1..255).
- ERR_CNT_WIDTH, 16: width of the saturating error counters.

Ports:
- clk  in  1  word-rate clock, single clock domain.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  deframer enable; low forces HUNT.
- in_frame  in  1  frame bit for the current word.
- in_data  in  6  current 6-bit word.
- out_valid  out  1  one-cycle strobe, new I/Q sample.
- out_i  out  12  I sample, two's complement.
- out_q  out  12  Q sample, two's complement.
- locked  out  1  high in LOCKED state.
- frame_err_cnt  out  ERR_CNT_WIDTH  saturating framing-error count.
- ramp_err_cnt  out  ERR_CNT_WIDTH  saturating ramp-error count (see Optional Feature).

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0, state HUNT, phase 0, input registers 0.
- Word order per sample: phase 0 = I[11:6], phase 1 = Q[11:6], phase 2 = I[5:0], phase 3 = Q[5:0].
- Expected frame: 1 in phases 0–1, 0 in phases 2–3.
- Stage 1 registers in_frame/in_data; all FSM decisions use the registered values.
- States:
  - HUNT: wait for registered frame 0→1 (previous word 0, current word 1). That word is phase 0; go to SYNC.
  - SYNC: check each word against expected frame. On phase 3, increment good-sample counter. When the counter reaches LOCK_COUNT, go to LOCKED; locked=1 from the next cycle.
  - LOCKED: same checks. On phase 3 with all four words correct, register out_i = {Ihi,Ilo} and out_q = {Qhi,Qlo}, and pulse out_valid.
- Latency: Q_lo presented in cycle N → out_valid high only in cycle N+2. out_i/out_q hold their value between strobes.
- No out_valid in HUNT or SYNC.
- Frame mismatch in SYNC or LOCKED:
  - go to HUNT next cycle; locked=0, good counter cleared;
  - frame_err_cnt +1, saturating at all-ones;
  - any partial sample is discarded;
  - the mismatching word is not used for edge detection, so re-acquisition starts at the following word.
- enable low: HUNT next cycle, locked=0, out_valid=0; counters unchanged, no error counted. The enable-low cycle wins over a simultaneous mismatch.
- Phase counter wraps 3→0.
- Counters clear only on reset.

Optional Feature:
- Macro: AD9361_TX_DEFRAMER_RAMP_CHECK_EN.
- Defined:
  - in LOCKED, each out_valid compares out_i against (previous out_i + 1) mod 4096;
  - on mismatch, ramp_err_cnt +1, saturating;
  - the first sample after entering LOCKED only loads the reference;
  - leaving LOCKED invalidates the reference.
- Undefined: no check logic is built; ramp_err_cnt is tied to 0.

Test Plan:
- Reset: rstn low mid-stream → outputs 0 immediately, all outputs at reset values; after release, first valid sample appears only after re-acquisition.
- Lock and decode:
  - Stimulus: repeated sample I=0xABC, Q=0x123 (words 0x2A,0x04,0x3C,0x23; frame 1,1,0,0), enable=1.
  - Response: locked after 4 good samples; each later sample gives out_valid one cycle, out_i=0xABC, out_q=0x123, 2 cycles after the Q_lo word.
- Frame error: invert frame on a phase-2 word while locked → locked=0 next cycle, frame_err_cnt=1, no out_valid until 4 further good samples relock.
- enable low for 3 cycles while locked → locked=0, frame_err_cnt unchanged; relocks after LOCK_COUNT samples once enable returns high.
- Saturation: ERR_CNT_WIDTH=4, inject 20 framing errors → frame_err_cnt=15, held.
- Ramp check:
  - Stimulus: I ramps 0,1,2,… after lock, value 10 skipped.
  - With macro: ramp_err_cnt=1.
  - Without macro: ramp_err_cnt stays 0.
